// File: rtl/t_ff_counter_if.sv
// Control and count bundle for t_ff_counter.
// The master drives the controls; the slave returns q, qb and tc.
interface t_ff_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;

    modport master (
        output en, up, load, load_val,
        input  q, qb, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output q, qb, tc
    );
endinterface

// File: rtl/t_ff_counter.sv
// N-bit up/down counter built from toggle-flop cells.
// Supports parallel load, a modulus bound, wrap or saturate, and a terminal-count flag.
module t_ff_cell (
    input  logic clk,
    input  logic async_reset,
    input  logic tog,
    input  logic ld,
    input  logic d,
    output logic q,
    output logic qb
);
    // qb is its own flop so it stays registered and glitch-free
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else if (ld) begin
            q  <= d;
            qb <= ~d;
        end else if (tog) begin
            q  <= ~q;
            qb <= q;
        end
    end
endmodule

module t_ff_counter #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input logic          clk,
    input logic          async_reset,
    t_ff_counter_if.slave bus
);
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] clamp_val;
    logic             ld;
    logic             at_max;
    logic             at_min;
    logic             bound;
    logic             tc_r;
    logic             run_up;
    logic             run_dn;

    always_comb begin
        at_max    = (q_r == MAX_VAL);
        at_min    = (q_r == '0);
        clamp_val = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        bound     = bus.en && !bus.load && (bus.up ? at_max : at_min);
        ld        = bus.load || bound;
        ld_val    = clamp_val;
        // The bound override reuses the cells' load path
        if (!bus.load && bound) begin
            if (SATURATE)
                ld_val = q_r;
            else
                ld_val = bus.up ? '0 : MAX_VAL;
        end
    end

    always_comb begin
        tog    = '0;
        run_up = 1'b1;
        run_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i] = bus.en && !bus.load && (bus.up ? run_up : run_dn);
            run_up = run_up & q_r[i];
            run_dn = run_dn & ~q_r[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk         (clk),
            .async_reset (async_reset),
            .tog         (tog[i]),
            .ld          (ld),
            .d           (ld_val[i]),
            .q           (q_r[i]),
            .qb          (qb_r[i])
        );
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset)
            tc_r <= 1'b0;
        else
            tc_r <= bound;
    end

    assign bus.q  = q_r;
    assign bus.qb = qb_r;
    assign bus.tc = tc_r;
endmodule

// File: tb/tb_t_ff_counter.sv
// Directed bench for t_ff_counter: wrap, saturate and single-bit builds.
// Inputs change #1 after each rising edge; outputs are checked there too.
module tb_t_ff_counter;
    logic clk;
    logic async_reset;
    int   nvec;
    int   nerr;

    t_ff_counter_if #(.WIDTH(4)) ifw ();
    t_ff_counter_if #(.WIDTH(4)) ifs ();
    t_ff_counter_if #(.WIDTH(1)) ifb ();

    t_ff_counter #(
        .WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)
    ) dut_wrap (
        .clk(clk), .async_reset(async_reset), .bus(ifw.slave)
    );

    t_ff_counter #(
        .WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)
    ) dut_sat (
        .clk(clk), .async_reset(async_reset), .bus(ifs.slave)
    );

    t_ff_counter #(
        .WIDTH(1), .MAX_VAL(1'b1), .SATURATE(1'b0)
    ) dut_bit (
        .clk(clk), .async_reset(async_reset), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        async_reset = 1'b1;
        ifw.en = 0; ifw.up = 1; ifw.load = 0; ifw.load_val = '0;
        ifs.en = 0; ifs.up = 1; ifs.load = 0; ifs.load_val = '0;
        ifb.en = 0; ifb.up = 1; ifb.load = 0; ifb.load_val = '0;
        step();
        step();
        nvec++;
        if ({ifw.q, ifw.qb, ifw.tc} !== {4'h0, 4'hF, 1'b0}) begin
            nerr++;
            $display("FAIL reset_wrap got q=%h qb=%h tc=%b want 0 f 0",
                     ifw.q, ifw.qb, ifw.tc);
        end
        nvec++;
        if ({ifs.q, ifs.qb, ifs.tc} !== {4'h0, 4'hF, 1'b0}) begin
            nerr++;
            $display("FAIL reset_sat got q=%h qb=%h tc=%b want 0 f 0",
                     ifs.q, ifs.qb, ifs.tc);
        end
        nvec++;
        if ({ifb.q, ifb.qb, ifb.tc} !== {1'b0, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL reset_bit got q=%b qb=%b tc=%b want 0 1 0",
                     ifb.q, ifb.qb, ifb.tc);
        end
        async_reset = 1'b0;
        step();
    endtask

    task automatic test_async_mid();
        ifw.load = 1; ifw.load_val = 4'd5;
        step();
        ifw.load = 0;
        nvec++;
        if (ifw.q !== 4'd5) begin
            nerr++;
            $display("FAIL async_preload got q=%0d want 5", ifw.q);
        end
        #2 async_reset = 1'b1;
        #1;
        nvec++;
        if ({ifw.q, ifw.qb, ifw.tc} !== {4'h0, 4'hF, 1'b0}) begin
            nerr++;
            $display("FAIL async_mid got q=%h qb=%h tc=%b want 0 f 0",
                     ifw.q, ifw.qb, ifw.tc);
        end
        #1 async_reset = 1'b0;
        ifw.en = 1; ifw.up = 1;
        step();
        ifw.en = 0;
        nvec++;
        if ({ifw.q, ifw.tc} !== {4'd1, 1'b0}) begin
            nerr++;
            $display("FAIL async_resume got q=%0d tc=%b want 1 0",
                     ifw.q, ifw.tc);
        end
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_q [11];
        logic       exp_tc [11];
        exp_q  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                   4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
        exp_tc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        ifw.load = 1; ifw.load_val = 4'd0;
        step();
        ifw.load = 0;
        ifw.en = 1; ifw.up = 1;
        for (int i = 0; i < 11; i++) begin
            step();
            nvec++;
            if ({ifw.q, ifw.qb, ifw.tc} !== {exp_q[i], ~exp_q[i], exp_tc[i]}) begin
                nerr++;
                $display("FAIL wrap_up[%0d] got q=%0d qb=%h tc=%b want %0d %h %b",
                         i, ifw.q, ifw.qb, ifw.tc, exp_q[i], ~exp_q[i], exp_tc[i]);
            end
        end
        ifw.en = 0;
    endtask

    task automatic test_wrap_down();
        ifw.load = 1; ifw.load_val = 4'd0;
        step();
        ifw.load = 0;
        ifw.en = 1; ifw.up = 0;
        step();
        nvec++;
        if ({ifw.q, ifw.tc} !== {4'd9, 1'b1}) begin
            nerr++;
            $display("FAIL wrap_down_bound got q=%0d tc=%b want 9 1",
                     ifw.q, ifw.tc);
        end
        step();
        nvec++;
        if ({ifw.q, ifw.tc} !== {4'd8, 1'b0}) begin
            nerr++;
            $display("FAIL wrap_down_step got q=%0d tc=%b want 8 0",
                     ifw.q, ifw.tc);
        end
        ifw.en = 0;
    endtask

    task automatic test_saturate();
        ifs.load = 1; ifs.load_val = 4'd9;
        step();
        ifs.load = 0;
        ifs.en = 1; ifs.up = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++;
            if ({ifs.q, ifs.tc} !== {4'd9, 1'b1}) begin
                nerr++;
                $display("FAIL sat_hi[%0d] got q=%0d tc=%b want 9 1",
                         i, ifs.q, ifs.tc);
            end
        end
        ifs.up = 0;
        step();
        nvec++;
        if ({ifs.q, ifs.qb, ifs.tc} !== {4'd8, 4'd7, 1'b0}) begin
            nerr++;
            $display("FAIL sat_down got q=%0d qb=%h tc=%b want 8 7 0",
                     ifs.q, ifs.qb, ifs.tc);
        end
        ifs.en = 0;
        ifs.load = 1; ifs.load_val = 4'd0;
        step();
        ifs.load = 0;
        ifs.en = 1; ifs.up = 0;
        step();
        nvec++;
        if ({ifs.q, ifs.tc} !== {4'd0, 1'b1}) begin
            nerr++;
            $display("FAIL sat_lo got q=%0d tc=%b want 0 1", ifs.q, ifs.tc);
        end
        ifs.en = 0;
        step();
        nvec++;
        if ({ifs.q, ifs.tc} !== {4'd0, 1'b0}) begin
            nerr++;
            $display("FAIL sat_idle got q=%0d tc=%b want 0 0", ifs.q, ifs.tc);
        end
    endtask

    task automatic test_load_clamp();
        ifw.load = 1; ifw.load_val = 4'd15;
        ifw.en = 1; ifw.up = 1;
        step();
        ifw.load = 0; ifw.en = 0;
        nvec++;
        if ({ifw.q, ifw.qb, ifw.tc} !== {4'd9, 4'd6, 1'b0}) begin
            nerr++;
            $display("FAIL load_clamp got q=%0d qb=%h tc=%b want 9 6 0",
                     ifw.q, ifw.qb, ifw.tc);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++;
            if ({ifw.q, ifw.qb, ifw.tc} !== {4'd9, 4'd6, 1'b0}) begin
                nerr++;
                $display("FAIL hold[%0d] got q=%0d qb=%h tc=%b want 9 6 0",
                         i, ifw.q, ifw.qb, ifw.tc);
            end
        end
        ifw.load = 1; ifw.load_val = 4'd6;
        step();
        ifw.load = 0;
        nvec++;
        if (ifw.q !== 4'd6) begin
            nerr++;
            $display("FAIL load_plain got q=%0d want 6", ifw.q);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_q [4];
        logic       dir [4];
        dir   = '{1, 1, 0, 1};
        exp_q = '{4'd8, 4'd9, 4'd8, 4'd9};
        ifw.load = 1; ifw.load_val = 4'd7;
        step();
        ifw.load = 0;
        ifw.en = 1;
        for (int i = 0; i < 4; i++) begin
            ifw.up = dir[i];
            step();
            nvec++;
            if ({ifw.q, ifw.tc} !== {exp_q[i], 1'b0}) begin
                nerr++;
                $display("FAIL dir_change[%0d] got q=%0d tc=%b want %0d 0",
                         i, ifw.q, ifw.tc, exp_q[i]);
            end
        end
        ifw.en = 0;
    endtask

    task automatic test_single_bit();
        logic exp_q [4];
        logic exp_tc [4];
        exp_q  = '{1, 0, 1, 0};
        exp_tc = '{0, 1, 0, 1};
        ifb.en = 1; ifb.up = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++;
            if ({ifb.q, ifb.qb, ifb.tc} !== {exp_q[i], ~exp_q[i], exp_tc[i]}) begin
                nerr++;
                $display("FAIL single_bit[%0d] got q=%b qb=%b tc=%b want %b %b %b",
                         i, ifb.q, ifb.qb, ifb.tc, exp_q[i], ~exp_q[i], exp_tc[i]);
            end
        end
        ifb.en = 0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_async_mid();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_clamp();
        test_back_to_back();
        test_single_bit();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
